// File: rtl/aes_enc_round_engine.sv
// Iterative AES encryption core: one full round per clock over a 128-bit state,
// round keys fetched combinationally from an external key store via roundIdx.
module aes_enc_round_engine #(
   parameter int unsigned NUM_ROUNDS = 14
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inValid,
   output logic         inReady,
   input  logic [127:0] inData,
   output logic [3:0]   roundIdx,
   input  logic [127:0] roundKey,
   output logic         outValid,
   input  logic         outReady,
   output logic [127:0] outData,
   output logic         busy
);

   localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

   // Entry 0 occupies bits [2047:2040].
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   state_t       fsm;
   logic [127:0] st;
   logic [3:0]   cnt;
   logic [127:0] sub_b;
   logic [127:0] shf;
   logic [127:0] mix;
   logic [127:0] round_out;
   logic         last_round;

   function automatic logic [7:0] sbox(input logic [7:0] b);
      int unsigned pos;
      pos = 32'd2040 - 32'(b) * 32'd8;
      return SBOX[pos +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   assign last_round = (cnt == LAST);

   // Byte k of the state sits at bits [127-8k -: 8]; column c is bytes 4c..4c+3.
   always_comb begin
      sub_b = '0;
      shf   = '0;
      mix   = '0;
      for (int unsigned i = 0; i < 16; i++)
         sub_b[127-8*i -: 8] = sbox(st[127-8*i -: 8]);
      for (int unsigned r = 0; r < 4; r++)
         for (int unsigned c = 0; c < 4; c++)
            shf[127-8*(r+4*c) -: 8] = sub_b[127-8*(r+4*((c+r)%4)) -: 8];
      for (int unsigned c = 0; c < 4; c++)
         mix[127-32*c -: 32] = mix_col(shf[127-32*c -: 32]);
      round_out = (last_round ? shf : mix) ^ roundKey;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm      <= IDLE;
         st       <= '0;
         cnt      <= '0;
         inReady  <= 1'b1;
         outValid <= 1'b0;
         busy     <= 1'b0;
      end else begin
         case (fsm)
            IDLE: if (inValid) begin
               st      <= inData ^ roundKey;
               cnt     <= 4'd1;
               fsm     <= ROUND;
               inReady <= 1'b0;
               busy    <= 1'b1;
            end
            ROUND: begin
               st <= round_out;
               if (last_round) begin
                  cnt      <= '0;
                  fsm      <= DONE;
                  outValid <= 1'b1;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            DONE: if (outReady) begin
               fsm      <= IDLE;
               outValid <= 1'b0;
               busy     <= 1'b0;
               inReady  <= 1'b1;
            end
            default: fsm <= IDLE;
         endcase
      end
   end

   // The counter is zero outside ROUND, so it doubles as the key index.
   assign roundIdx = cnt;
   assign outData  = (fsm == DONE) ? st : '0;

endmodule

// File: tb/tb_aes_enc_round_engine.sv
// Bench for aes_enc_round_engine: behavioural AES-256 reference with its own
// derived S-box, a key store driven by roundIdx, and a queue of expected blocks.
module tb_aes_enc_round_engine;

   localparam int NR = 14;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [3:0]   round_idx;
   logic [127:0] round_key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         busy;

   logic [7:0]   sb [256];
   logic [127:0] rk [16];
   logic [127:0] exp_q [$];
   int           total = 0;
   int           passed = 0;
   int           cyc = 0;
   int           last_acc = 0;

   aes_enc_round_engine #(.NUM_ROUNDS(NR)) dut (
      .clk      (clk),
      .rst      (rst),
      .inValid  (in_valid),
      .inReady  (in_ready),
      .inData   (in_data),
      .roundIdx (round_idx),
      .roundKey (round_key),
      .outValid (out_valid),
      .outReady (out_ready),
      .outData  (out_data),
      .busy     (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign round_key = rk[round_idx];

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = {1'b0, y[7:1]};
      end
      return p;
   endfunction

   // S-box from the multiplicative inverse plus affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                 {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] sub_word(input logic [31:0] t);
      return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
   endfunction

   task automatic expand_key(input logic [255:0] key);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
      for (int i = 8; i < 60; i++) begin
         t = w[i-1];
         if (i % 8 == 0) begin
            t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end else if (i % 8 == 4) begin
            t = sub_word(t);
         end
         w[i] = w[i-8] ^ t;
      end
      for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      rk[15] = '0;
   endtask

   function automatic logic [127:0] model_enc(input logic [127:0] pt);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
      for (int r = 1; r <= NR; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
         for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++)
               s[row+4*col] = t[row+4*((col+row)%4)];
         if (r < NR) begin
            for (int col = 0; col < 4; col++) begin
               a0 = s[4*col]; a1 = s[4*col+1]; a2 = s[4*col+2]; a3 = s[4*col+3];
               s[4*col]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               s[4*col+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               s[4*col+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               s[4*col+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127-8*i -: 8];
      end
      res = '0;
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   // Runs one block starting from a negedge with the engine idle.
   task automatic do_block(input logic [127:0] pt, input logic [255:0] key,
                           input logic [127:0] fixed_ct, input bit use_fixed,
                           input bit perturb, input int bp, input bit hold_valid,
                           input int abort_at, input int exp_gap);
      logic [127:0] exp_ct;
      int e;
      expand_key(key);
      in_data   = pt;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      exp_ct    = use_fixed ? fixed_ct : model_enc(pt);
      check("idle_state", {in_ready, busy, out_valid, round_idx, out_data},
            {1'b1, 1'b0, 1'b0, 4'd0, 128'h0});
      @(posedge clk); #1;
      if (exp_gap > 0) check("accept_gap", cyc - last_acc, exp_gap);
      last_acc = cyc;
      exp_q.push_back(exp_ct);
      @(negedge clk);
      in_valid = hold_valid;
      e = 0;
      while (!out_valid && e <= NR + 2) begin
         check("round_seq", {busy, in_ready, out_data, round_idx},
               {1'b1, 1'b0, 128'h0, 4'(e + 1)});
         if (e == abort_at) begin
            rst = 1'b1;
            #1;
            check("abort_reset", {in_ready, out_valid, busy, round_idx, out_data},
                  {1'b1, 1'b0, 1'b0, 4'd0, 128'h0});
            void'(exp_q.pop_front());
            in_valid = 1'b0;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            e = 0;
            repeat (20) begin
               @(negedge clk);
               if (out_valid || busy) e++;
            end
            check("abort_quiet", e, 0);
            return;
         end
         if (perturb) begin
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            in_valid = 1'($urandom);
         end
         @(negedge clk);
         e++;
      end
      check("latency", e, NR);
      for (int k = 0; k < bp; k++) begin
         check("bp_hold", {out_valid, in_ready, round_idx, out_data},
               {1'b1, 1'b0, 4'd0, exp_q[0]});
         if (perturb) begin
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            in_valid = 1'($urandom);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      in_valid  = hold_valid;
      check("out_data", {out_valid, out_data}, {1'b1, exp_q.pop_front()});
      @(negedge clk);
      out_ready = 1'b0;
      check("idle_after", {in_ready, out_valid, busy, round_idx, out_data},
            {1'b1, 1'b0, 1'b0, 4'd0, 128'h0});
   endtask

   localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) rk[i] = '0;
      build_sbox();
      #3;
      check("reset_state", {in_ready, out_valid, busy, round_idx, out_data},
            {1'b1, 1'b0, 1'b0, 4'd0, 128'h0});
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      do_block(C3_PT, C3_KEY, C3_CT, 1'b1, 1'b0, 0, 1'b0, -1, 0);
      do_block(C3_PT, C3_KEY, C3_CT, 1'b1, 1'b1, 10, 1'b0, -1, 0);

      do_block({$urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
               '0, 1'b0, 1'b0, 0, 1'b1, -1, 0);
      do_block({$urandom, $urandom, $urandom, $urandom},
               {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
               '0, 1'b0, 1'b0, 0, 1'b0, -1, 16);

      do_block(C3_PT, C3_KEY, C3_CT, 1'b1, 1'b0, 0, 1'b0, 6, 0);
      do_block(C3_PT, C3_KEY, C3_CT, 1'b1, 1'b0, 0, 1'b0, -1, 0);

      for (int n = 0; n < 1000; n++)
         do_block({$urandom, $urandom, $urandom, $urandom},
                  {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                  '0, 1'b0, 1'b1, int'($urandom_range(3, 0)), 1'b0, -1, 0);

      check("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/aes_enc_round_engine.md
AES_ENC_ROUND_ENGINE -- requirements
Module: aes_enc_round_engine

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 14, meaning the number of AES rounds after the initial AddRoundKey (AES-256); legal range 1..14.
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  meaning the reset; asynchronous and active-high.
REQ-004 SHALL have port inValid  input  1  meaning the plaintext block on inData is offered.
REQ-005 SHALL have port inReady  output  1  meaning the engine accepts a block this cycle.
REQ-006 SHALL have port inData  input  128  meaning the plaintext block; byte 0 = inData[127:120], column-major FIPS-197 state order.
REQ-007 SHALL have port roundIdx  output  4  meaning the index of the round key the engine needs this cycle.
REQ-008 SHALL have port roundKey  input  128  meaning round key[roundIdx], driven combinationally by the external key store in the same cycle; same byte order as inData.
REQ-009 SHALL have port outValid  output  1  meaning a ciphertext block is presented on outData.
REQ-010 SHALL have port outReady  input  1  meaning the consumer takes outData this cycle.
REQ-011 SHALL have port outData  output  128  meaning the ciphertext block; same byte order as inData.
REQ-012 SHALL have port busy  output  1  meaning a block is in progress (state ROUND or DONE).

Function
REQ-013 SHALL implement a three-state FSM: IDLE, ROUND, DONE; a 128-bit state register; a 4-bit round counter.
REQ-014 SHALL drive inReady=1 only in IDLE; outValid=1 only in DONE; busy=1 in ROUND and DONE.
REQ-015 In IDLE, roundIdx SHALL be 0; on inValid&inReady, the engine SHALL load state <= inData XOR roundKey, set counter to 1, and enter ROUND.
REQ-016 In ROUND, roundIdx SHALL equal counter; each cycle, state SHALL be updated to AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), roundKey) when counter < NUM_ROUNDS.
REQ-017 When counter == NUM_ROUNDS, MixColumns SHALL be omitted, the FSM SHALL enter DONE, and the counter SHALL clear to 0.
REQ-018 SubBytes SHALL apply the FIPS-197 S-box bytewise to all 16 bytes in parallel; ShiftRows and MixColumns SHALL follow FIPS-197 over GF(2^8), polynomial 0x11B.
REQ-019 Each round SHALL be purely combinational between state register and register input, one round per clock.
REQ-020 Latency SHALL be fixed: outValid rises NUM_ROUNDS clock edges after the acceptance edge (14 for default).
REQ-021 In DONE, roundIdx SHALL be 0; outData SHALL equal the state register and SHALL remain stable while outValid=1 and outReady=0.
REQ-022 On outValid&outReady, the FSM SHALL return to IDLE; a new block SHALL NOT be accepted in that same cycle (throughput one block per NUM_ROUNDS+2 cycles minimum).
REQ-023 inData, inValid and roundKey SHALL be ignored outside the cycles listed above; changing them while busy SHALL not affect the result.
REQ-024 outData SHALL be 0 in IDLE and ROUND (internal state not exposed).
REQ-025 roundIdx SHALL never exceed NUM_ROUNDS.

Reset
REQ-026 While rst=1, asynchronously: FSM=IDLE, state register=0, counter=0, inReady=1 after the FSM reaches IDLE, outValid=0, busy=0, roundIdx=0, outData=0.
REQ-027 Assertion of rst mid-block (ROUND or DONE) SHALL abort the block with no output; the first accept after release SHALL behave as from power-up.

Verification
REQ-028 FIPS-197 C.3: plaintext 00112233445566778899aabbccddeeff, key 000102...1f (bench key store serves expanded keys on roundIdx) -> outValid after 14 edges, outData = 8ea2b7ca516745bfeafc49904b496089.
REQ-029 Backpressure: hold outReady=0 for 10 cycles after outValid -> outData stable, inReady=0, roundIdx=0 throughout; release -> IDLE next cycle.
REQ-030 Back-to-back: inValid held high with two blocks, outReady=1 -> second accept exactly 16 cycles after first, both outputs match reference model.
REQ-031 Reset at round 7 of a block -> outValid never rises for it, all outputs at REQ-026 values; next block yields correct ciphertext with 14-edge latency.
REQ-032 Busy perturbation: randomize inData/inValid while busy, 1000 random plaintext/key pairs -> every outData matches software AES-256 model; roundIdx sequence 0,1..14 per block.
